// File: rtl/mo_line_scanner.sv
// Per-scanline motion-object table walker: reads each 2-word entry from working RAM, matches its
// vertical position against the prepared line and hands hits to the line-buffer writer.
module mo_line_scanner #(
    parameter int unsigned MO_COUNT     = 32,
    parameter int unsigned MO_HEIGHT    = 16,
    parameter int unsigned MAX_PER_LINE = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        line_start,
    input  logic [7:0]  vline,
    output logic        rd_en,
    output logic [6:0]  rd_addr,
    input  logic [15:0] sr_data,
    output logic        mo_valid,
    input  logic        mo_ready,
    output logic [7:0]  mo_pic,
    output logic [7:0]  mo_attr,
    output logic [7:0]  mo_hpos,
    output logic [3:0]  mo_row,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam int unsigned CntW      = $clog2(MAX_PER_LINE + 1);
    localparam logic [5:0]  LastEntry = 6'(MO_COUNT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd0,
        StRd1,
        StEval,
        StEmit,
        StNext
    } state_e;

    state_e          state;
    logic [5:0]      entry;
    logic [5:0]      entry_nxt;
    logic [CntW-1:0] hit_cnt;
    logic [7:0]      vline_q;
    logic [7:0]      vpos_q;
    logic [7:0]      pic_q;
    logic [7:0]      diff;
    logic            hit;

    assign entry_nxt = entry + 6'd1;
    // 8-bit wrap lets objects starting near line 255 cover the top lines of the next field.
    assign diff      = vline_q - vpos_q;
    assign hit       = 32'(diff) < MO_HEIGHT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            entry    <= 6'd0;
            hit_cnt  <= '0;
            vline_q  <= 8'd0;
            vpos_q   <= 8'd0;
            pic_q    <= 8'd0;
            rd_en    <= 1'b0;
            rd_addr  <= 7'd0;
            mo_valid <= 1'b0;
            mo_pic   <= 8'd0;
            mo_attr  <= 8'd0;
            mo_hpos  <= 8'd0;
            mo_row   <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            // A new line always (re)starts the walk, even mid-scan or mid-handshake.
            if (line_start) begin
                state    <= StRd0;
                vline_q  <= vline;
                entry    <= 6'd0;
                hit_cnt  <= '0;
                overflow <= 1'b0;
                mo_valid <= 1'b0;
                rd_en    <= 1'b1;
                rd_addr  <= 7'd0;
                busy     <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: begin
                        busy <= 1'b0;
                    end
                    StRd0: begin
                        rd_addr <= {entry, 1'b1};
                        state   <= StRd1;
                    end
                    StRd1: begin
                        rd_en  <= 1'b0;
                        vpos_q <= sr_data[15:8];
                        pic_q  <= sr_data[7:0];
                        state  <= StEval;
                    end
                    StEval: begin
                        if (hit && (32'(hit_cnt) < MAX_PER_LINE)) begin
                            mo_pic   <= pic_q;
                            mo_hpos  <= sr_data[15:8];
                            mo_attr  <= sr_data[7:0];
                            mo_row   <= diff[3:0];
                            mo_valid <= 1'b1;
                            hit_cnt  <= hit_cnt + CntW'(1);
                            state    <= StEmit;
                        end else begin
                            if (hit) begin
                                overflow <= 1'b1;
                            end
                            state <= StNext;
                        end
                    end
                    StEmit: begin
                        if (mo_ready) begin
                            mo_valid <= 1'b0;
                            state    <= StNext;
                        end
                    end
                    StNext: begin
                        if (entry == LastEntry) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= StIdle;
                        end else begin
                            entry   <= entry_nxt;
                            rd_en   <= 1'b1;
                            rd_addr <= {entry_nxt, 1'b0};
                            state   <= StRd0;
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mo_line_scanner.sv
// Bench for mo_line_scanner: directed vector table, multi-cycle corner sequences and randomized
// tables checked against a list-based reference of which objects land on a line.
module tb_mo_line_scanner;

    localparam int MoCount    = 32;
    localparam int MoHeight   = 16;
    localparam int MaxPerLine = 8;
    localparam int Budget     = 5000;

    typedef logic [27:0] desc_t;  // {pic, attr, hpos, row}

    typedef struct {
        logic [7:0] vpos;
        logic [7:0] pic;
        logic [7:0] hpos;
        logic [7:0] attr;
        logic [7:0] vl;
        logic       hit;
        logic [3:0] row;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic [7:0]  vline = 8'd0;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [15:0] sr_data = 16'd0;
    logic        mo_valid;
    logic        mo_ready = 1'b0;
    logic [7:0]  mo_pic;
    logic [7:0]  mo_attr;
    logic [7:0]  mo_hpos;
    logic [3:0]  mo_row;
    logic        busy;
    logic        done;
    logic        overflow;

    logic [15:0] ram [128];
    desc_t       got_q[$];
    desc_t       exp_q[$];
    logic        exp_ovf;
    int          total = 0;
    int          bad = 0;
    int          ndone;
    int          done_idx;
    int          unstable;
    int          stall_reads;
    vec_t        vecs[8];

    mo_line_scanner #(
        .MO_COUNT    (MoCount),
        .MO_HEIGHT   (MoHeight),
        .MAX_PER_LINE(MaxPerLine)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .line_start(line_start),
        .vline     (vline),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .sr_data   (sr_data),
        .mo_valid  (mo_valid),
        .mo_ready  (mo_ready),
        .mo_pic    (mo_pic),
        .mo_attr   (mo_attr),
        .mo_hpos   (mo_hpos),
        .mo_row    (mo_row),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Working RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) sr_data <= ram[rd_addr];
    end

    function automatic desc_t cur_desc();
        return {mo_pic, mo_attr, mo_hpos, mo_row};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Every entry placed half a frame away from vl, so nothing hits.
    task automatic fill_nohit(input logic [7:0] vl);
        for (int e = 0; e < 64; e++) begin
            ram[2*e]   = {vl ^ 8'h80, 8'(e)};
            ram[2*e+1] = {8'(e * 3), 8'(e + 1)};
        end
    endtask

    // Reference: walk the table in order, keep the first MaxPerLine objects covering vl.
    task automatic build_expect(input logic [7:0] vl);
        int d;
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int e = 0; e < MoCount; e++) begin
            d = (int'(vl) - int'(ram[2*e][15:8]) + 256) % 256;
            if (d < MoHeight) begin
                if (exp_q.size() < MaxPerLine)
                    exp_q.push_back({ram[2*e][7:0], ram[2*e+1][7:0], ram[2*e+1][15:8], 4'(d)});
                else
                    exp_ovf = 1'b1;
            end
        end
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low 20 cycles on the first descriptor.
    task automatic run_scan(input logic [7:0] vl, input int mode);
        int   idx;
        bit   finished;
        int   stall_state;
        int   stall_cnt;
        desc_t held;
        got_q.delete();
        ndone = 0;
        done_idx = -1;
        unstable = 0;
        stall_reads = 0;
        stall_state = 0;
        stall_cnt = 0;
        finished = 0;
        held = '0;
        @(negedge clk);
        vline = vl;
        line_start = 1'b1;
        mo_ready = (mode == 0);
        @(negedge clk);
        line_start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_rd", {rd_en, rd_addr}, {1'b1, 7'd0});
        idx = 0;
        while (!finished && idx < Budget) begin
            if (done) begin
                ndone++;
                done_idx = idx;
                finished = 1;
            end
            if (mode == 2) begin
                if (stall_state == 1) begin
                    if (!mo_valid || cur_desc() != held) unstable++;
                    if (rd_en) stall_reads++;
                    stall_cnt++;
                    if (stall_cnt == 20) stall_state = 2;
                end else if (stall_state == 0 && mo_valid) begin
                    held = cur_desc();
                    stall_state = 1;
                end
                mo_ready = (stall_state == 2);
            end else if (mode == 1) begin
                mo_ready = ($urandom_range(0, 9) < 7);
            end
            // Values now on the pins are what the DUT samples at the coming edge.
            if (mo_valid && mo_ready) got_q.push_back(cur_desc());
            if (!finished) begin
                @(negedge clk);
                idx++;
            end
        end
        if (!finished) check("scan_timeout", 32'd0, 32'd1);
        check("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic compare_scan(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_desc%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        int   idx;
        int   nvalid;
        logic [7:0] vl;

        vecs[0] = '{8'h10, 8'h22, 8'h40, 8'h81, 8'h15, 1'b1, 4'd5};
        vecs[1] = '{8'h10, 8'h22, 8'h40, 8'h81, 8'h20, 1'b0, 4'd0};
        vecs[2] = '{8'h10, 8'h33, 8'h41, 8'h82, 8'h1F, 1'b1, 4'd15};
        vecs[3] = '{8'hF8, 8'h44, 8'h42, 8'h83, 8'h03, 1'b1, 4'd11};
        vecs[4] = '{8'h10, 8'h55, 8'h43, 8'h84, 8'h10, 1'b1, 4'd0};
        vecs[5] = '{8'h10, 8'h66, 8'h44, 8'h85, 8'h0F, 1'b0, 4'd0};
        vecs[6] = '{8'hFF, 8'h77, 8'h45, 8'h86, 8'h0E, 1'b1, 4'd15};
        vecs[7] = '{8'hFF, 8'h88, 8'h46, 8'h87, 8'h0F, 1'b0, 4'd0};
        fill_nohit(8'h00);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rd", {rd_en, rd_addr}, 32'd0);
        check("rst_desc", {mo_valid, cur_desc()}, 32'd0);
        check("rst_flags", {busy, done, overflow}, 32'd0);
        reset_n = 1'b1;

        // Single-entry vector table
        for (int v = 0; v < 8; v++) begin
            fill_nohit(vecs[v].vl);
            ram[0] = {vecs[v].vpos, vecs[v].pic};
            ram[1] = {vecs[v].hpos, vecs[v].attr};
            exp_q.delete();
            exp_ovf = 1'b0;
            if (vecs[v].hit)
                exp_q.push_back({vecs[v].pic, vecs[v].attr, vecs[v].hpos, vecs[v].row});
            run_scan(vecs[v].vl, 0);
            compare_scan($sformatf("vec%0d", v));
            check($sformatf("vec%0d_done_time", v), 32'(done_idx), 32'(128 + (vecs[v].hit ? 1 : 0)));
        end

        // Ten hits: eight emitted in entry order, overflow after the ninth
        fill_nohit(8'h30);
        for (int e = 0; e < 10; e++) begin
            ram[2*e]   = {8'h30, 8'(8'h50 + e)};
            ram[2*e+1] = {8'(e), 8'(8'hA0 + e)};
        end
        build_expect(8'h30);
        run_scan(8'h30, 0);
        compare_scan("ovf10");
        check("ovf10_done_time", 32'(done_idx), 32'd136);

        // Ready held low on the first descriptor
        build_expect(8'h30);
        run_scan(8'h30, 2);
        compare_scan("stall");
        check("stall_stable", 32'(unstable), 32'd0);
        check("stall_noread", 32'(stall_reads), 32'd0);
        check("stall_done_time", 32'(done_idx), 32'd156);

        // Abort after overflow, then abort while holding a descriptor
        ndone = 0;
        @(negedge clk);
        vline = 8'h30;
        line_start = 1'b1;
        mo_ready = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        for (idx = 0; idx < 300 && !overflow; idx++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort_ovf_set", 32'(overflow), 32'd1);
        vline = 8'h35;
        line_start = 1'b1;
        mo_ready = 1'b0;
        @(negedge clk);
        line_start = 1'b0;
        check("abort1_ovf_clr", 32'(overflow), 32'd0);
        check("abort1_state", {busy, done, rd_en, rd_addr}, {1'b1, 1'b0, 1'b1, 7'd0});
        for (idx = 0; idx < 50 && !mo_valid; idx++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort1_first", {mo_valid, mo_pic, mo_row}, {1'b1, 8'h50, 4'd5});
        vline = 8'h40;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        mo_ready = 1'b1;
        check("abort2_valid", 32'(mo_valid), 32'd0);
        check("abort2_state", {busy, rd_en, rd_addr}, {1'b1, 1'b1, 7'd0});
        check("abort_no_done", 32'(ndone), 32'd0);
        nvalid = 0;
        done_idx = -1;
        for (idx = 0; idx < 300 && done_idx < 0; idx++) begin
            if (mo_valid) nvalid++;
            if (done) done_idx = idx;
            else @(negedge clk);
        end
        check("abort2_done_time", 32'(done_idx), 32'd128);
        check("abort2_nohits", 32'(nvalid), 32'd0);

        // Reset mid-scan: outputs clear at once, no done pulse
        fill_nohit(8'h15);
        ram[0] = {8'h10, 8'h22};
        ram[1] = {8'h40, 8'h81};
        @(negedge clk);
        vline = 8'h15;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        mo_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_valid", 32'(mo_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_out", {busy, rd_en, mo_valid, rd_addr, cur_desc()}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        repeat (200) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);

        // Randomized tables against the reference
        for (int it = 0; it < 12; it++) begin
            vl = 8'($urandom_range(0, 255));
            for (int e = 0; e < 64; e++) begin
                if ($urandom_range(0, 2) != 0)
                    ram[2*e] = {vl - 8'($urandom_range(0, 20)), 8'($urandom)};
                else
                    ram[2*e] = 16'($urandom);
                ram[2*e+1] = 16'($urandom);
            end
            build_expect(vl);
            run_scan(vl, 1);
            compare_scan($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
